// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Minimum binary width able to hold 10**digits-1.
  function automatic int bcd_bin_width(input int digits);
    longint unsigned m;
    int w;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    m = m - 1;
    w = 0;
    for (int i = 0; i < 64; i++) begin
      if (m != 0) begin
        w++;
        m = m >> 1;
      end
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational check: flags a packed BCD word containing any digit above 9.
module bcd_digit_check
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          any_invalid
);

  logic [DIGITS-1:0] bad;

  // One comparator per digit, OR-reduced below.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign bad[k] = (bcd_in[BCD_DIGIT_W*k +: BCD_DIGIT_W] > BCD_MAX_DIGIT);
  end

  assign any_invalid = |bad;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential multi-digit BCD-to-binary converter, one digit per clock, MSD
// first (acc = acc*10 + digit), valid/ready on both sides.
// Optional macro BCD2B_ERR_CNT_EN adds a saturating 8-bit error-word counter.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
`ifdef BCD2B_ERR_CNT_EN
  ,
  output logic [7:0]                    err_cnt
`endif
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1) begin : g_chk_digits
    $error("bcd_to_bin_seq: DIGITS must be at least 1");
  end
  if (BIN_W < bcd_bin_width(DIGITS)) begin : g_chk_width
    $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
  end

  state_t                          state, state_nx;
  logic [BCD_DIGIT_W*DIGITS-1:0]   sreg;
  logic [BIN_W-1:0]                acc;
  logic [CNT_W-1:0]                cnt;
  logic                            err_q;
  logic                            any_invalid;
  logic [BCD_DIGIT_W-1:0]          msd;
  logic                            accept;
  logic                            hshk;

  bcd_digit_check #(.DIGITS(DIGITS)) u_check (
    .bcd_in      (bcd_in),
    .any_invalid (any_invalid)
  );

  assign msd    = sreg[BCD_DIGIT_W*DIGITS-1 -: BCD_DIGIT_W];
  assign accept = in_valid && in_ready;
  assign hshk   = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs; in_ready is masked by rst so it reads
  // low for the whole reset pulse, not just after the first edge.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nx = CONV;
      end
      CONV: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result is only presented in DONE, and forced to zero for bad words.
  assign bin_out = (out_valid && !err_q) ? acc : '0;
  assign err     = out_valid && err_q;

  // Datapath: capture on accept, then shift one digit per CONV cycle. The
  // loop runs the full length even for bad words so latency is fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      sreg  <= bcd_in;
      acc   <= '0;
      cnt   <= CNT_W'(DIGITS - 1);
      err_q <= any_invalid;
    end else if (state == CONV) begin
      acc  <= (acc << 3) + (acc << 1) + BIN_W'(msd);
      sreg <= sreg << BCD_DIGIT_W;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

`ifdef BCD2B_ERR_CNT_EN
  // Saturating count of erroneous words delivered downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_cnt <= '0;
    else if (hshk && err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  logic unused_hshk;
  assign unused_hshk = hshk;
`endif

endmodule
